uart_rx_sched: RTL and testbench

//  Sequences reception of 8N1 UART frames. Owns baud/oversample timing, start-bit

---
 rtl/uart_rx_sched.sv | 194 +++++++++++++++++++
 tb/tb_uart_rx_sched.sv | 259 +++++++++++++++++++++++++
 2 files changed

// File: rtl/uart_rx_sched.sv
// uart_rx_sched: 8N1 UART receiver with oversampled mid-bit sampling and an FWFT byte FIFO.
// Optional parity support is compiled in with `define UART_RX_PARITY_EN.
module uart_rx_sched #(
    parameter int unsigned CLK_FREQ   = 50_000_000,
    parameter int unsigned BAUD       = 115200,
    parameter int unsigned OVERSAMPLE = 16,
`ifdef UART_RX_PARITY_EN
    parameter bit          ODD_PARITY = 1'b0,
`endif
    parameter int unsigned FIFO_DEPTH = 4
) (
    input  logic       clk,
    input  logic       rst_n,
    input  logic       rxd,
    output logic [7:0] rx_data,
    output logic       rx_valid,
    input  logic       rx_ready,
    output logic       frame_err,
    output logic       overrun,
`ifdef UART_RX_PARITY_EN
    output logic       parity_err,
`endif
    output logic       busy
);

    localparam int unsigned DIV_RAW = CLK_FREQ / (BAUD * OVERSAMPLE);
    localparam int unsigned DIV     = (DIV_RAW == 0) ? 1 : DIV_RAW;
    localparam int unsigned DIV_W   = (DIV > 1) ? $clog2(DIV) : 1;
    localparam int unsigned TC_W    = $clog2(OVERSAMPLE);
    localparam int unsigned PTR_W   = $clog2(FIFO_DEPTH);

    typedef enum logic [2:0] {
        StIdle,
        StStart,
        StData,
        StStop
`ifdef UART_RX_PARITY_EN
        , StParity
`endif
    } state_e;

    state_e            state_q;
    logic              sync_q;
    logic              rxs_q;
    logic [DIV_W-1:0]  div_q;
    logic [TC_W-1:0]   tc_q;
    logic [2:0]        bit_q;
    logic [7:0]        shift_q;
`ifdef UART_RX_PARITY_EN
    logic              par_bad_q;
`endif

    logic              tick;
    logic              tc_half;
    logic              tc_full;
    logic              push;
    logic              pop;
    logic              full;
    logic              empty;

    logic [7:0]        mem_q [FIFO_DEPTH];
    logic [PTR_W:0]    wr_q;
    logic [PTR_W:0]    rd_q;

    // Two-flop synchronizer; preset high so reset does not look like a start edge.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            sync_q <= 1'b1;
            rxs_q  <= 1'b1;
        end else begin
            sync_q <= rxd;
            rxs_q  <= sync_q;
        end
    end

    assign tick    = (div_q == DIV_W'(DIV - 1));
    assign tc_half = (tc_q == TC_W'(OVERSAMPLE / 2 - 1));
    assign tc_full = (tc_q == TC_W'(OVERSAMPLE - 1));
    assign busy    = (state_q != StIdle);

`ifdef UART_RX_PARITY_EN
    assign push = (state_q == StStop) && tick && tc_full && rxs_q && !par_bad_q;
`else
    assign push = (state_q == StStop) && tick && tc_full && rxs_q;
`endif

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state_q    <= StIdle;
            div_q      <= '0;
            tc_q       <= '0;
            bit_q      <= '0;
            shift_q    <= '0;
            frame_err  <= 1'b0;
`ifdef UART_RX_PARITY_EN
            par_bad_q  <= 1'b0;
            parity_err <= 1'b0;
`endif
        end else begin
            frame_err  <= 1'b0;
`ifdef UART_RX_PARITY_EN
            parity_err <= 1'b0;
`endif
            div_q <= tick ? '0 : div_q + 1'b1;
            unique case (state_q)
                StIdle: begin
                    // Holding the timebase cleared here aligns ticks to the start edge.
                    div_q <= '0;
                    tc_q  <= '0;
                    bit_q <= '0;
                    if (!rxs_q) state_q <= StStart;
                end
                StStart: begin
                    if (tick) begin
                        if (tc_half) begin
                            tc_q    <= '0;
                            state_q <= rxs_q ? StIdle : StData;
                        end else begin
                            tc_q <= tc_q + 1'b1;
                        end
                    end
                end
                StData: begin
                    if (tick) begin
                        if (tc_full) begin
                            tc_q    <= '0;
                            shift_q <= {rxs_q, shift_q[7:1]};
                            bit_q   <= bit_q + 1'b1;
`ifdef UART_RX_PARITY_EN
                            if (bit_q == 3'd7) state_q <= StParity;
`else
                            if (bit_q == 3'd7) state_q <= StStop;
`endif
                        end else begin
                            tc_q <= tc_q + 1'b1;
                        end
                    end
                end
`ifdef UART_RX_PARITY_EN
                StParity: begin
                    if (tick) begin
                        if (tc_full) begin
                            tc_q      <= '0;
                            par_bad_q <= rxs_q ^ (^shift_q) ^ ODD_PARITY;
                            state_q   <= StStop;
                        end else begin
                            tc_q <= tc_q + 1'b1;
                        end
                    end
                end
`endif
                StStop: begin
                    if (tick) begin
                        if (tc_full) begin
                            frame_err  <= !rxs_q;
`ifdef UART_RX_PARITY_EN
                            parity_err <= rxs_q & par_bad_q;
`endif
                            state_q    <= StIdle;
                        end else begin
                            tc_q <= tc_q + 1'b1;
                        end
                    end
                end
                default: state_q <= StIdle;
            endcase
        end
    end

    // FWFT FIFO; pointer MSB separates full from empty.
    assign empty    = (wr_q == rd_q);
    assign full     = (wr_q[PTR_W] != rd_q[PTR_W]) &&
                      (wr_q[PTR_W-1:0] == rd_q[PTR_W-1:0]);
    assign rx_valid = !empty;
    assign rx_data  = mem_q[rd_q[PTR_W-1:0]];
    assign pop      = rx_valid & rx_ready;

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            wr_q    <= '0;
            rd_q    <= '0;
            overrun <= 1'b0;
            for (int i = 0; i < FIFO_DEPTH; i++) mem_q[i] <= '0;
        end else begin
            overrun <= push & full & !pop;
            if (push && (!full || pop)) begin
                mem_q[wr_q[PTR_W-1:0]] <= shift_q;
                wr_q <= wr_q + 1'b1;
            end
            if (pop) rd_q <= rd_q + 1'b1;
        end
    end

endmodule

// File: tb/tb_uart_rx_sched.sv
// Directed bench for uart_rx_sched at 16 clk/bit; received bytes are checked against a
// scoreboard queue filled as frames are driven.
module tb_uart_rx_sched;

    localparam int unsigned BIT_CLKS = 16;

    logic       clk = 1'b0;
    logic       rst_n;
    logic       rxd;
    logic       rx_ready;
    logic [7:0] rx_data;
    logic       rx_valid;
    logic       frame_err;
    logic       overrun;
    logic       busy;
`ifdef UART_RX_PARITY_EN
    logic       parity_err;
    logic       par_flip = 1'b0;
    int         pe_cnt;
`endif

    int         checks   = 0;
    int         failures = 0;
    int         valid_cycles;
    int         busy_cycles;
    int         fe_cnt;
    int         ov_cnt;
    logic [7:0] exp_q [$];

    uart_rx_sched #(
        .CLK_FREQ   (1_600_000),
        .BAUD       (100_000),
        .OVERSAMPLE (16),
`ifdef UART_RX_PARITY_EN
        .ODD_PARITY (1'b0),
`endif
        .FIFO_DEPTH (4)
    ) dut (
        .clk        (clk),
        .rst_n      (rst_n),
        .rxd        (rxd),
        .rx_data    (rx_data),
        .rx_valid   (rx_valid),
        .rx_ready   (rx_ready),
        .frame_err  (frame_err),
        .overrun    (overrun),
`ifdef UART_RX_PARITY_EN
        .parity_err (parity_err),
`endif
        .busy       (busy)
    );

    always #5 clk = ~clk;

    task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        checks++;
        assert (obs === exp) else begin
            failures++;
            $error("FAIL %s: observed=%0h expected=%0h", tag, obs, exp);
        end
    endtask

    task automatic clks(input int n);
        repeat (n) @(posedge clk);
        #1;
    endtask

    task automatic clear_stats();
        valid_cycles = 0;
        busy_cycles  = 0;
        fe_cnt       = 0;
        ov_cnt       = 0;
`ifdef UART_RX_PARITY_EN
        pe_cnt       = 0;
`endif
    endtask

    // Drives one frame; optionally pulses rx_ready on the edge the stop bit is sampled.
    task automatic send(input logic [7:0] b, input logic stop_v, input bit store,
                        input bit pop_on_push);
        if (store) exp_q.push_back(b);
        rxd = 1'b0;
        clks(BIT_CLKS);
        for (int i = 0; i < 8; i++) begin
            rxd = b[i];
            clks(BIT_CLKS);
        end
`ifdef UART_RX_PARITY_EN
        rxd = (^b) ^ par_flip;
        clks(BIT_CLKS);
`endif
        rxd = stop_v;
        if (pop_on_push) begin
            clks(10);
            rx_ready = 1'b1;
            clks(1);
            rx_ready = 1'b0;
            clks(5);
        end else begin
            clks(BIT_CLKS);
        end
        rxd = 1'b1;
    endtask

    // Output monitor: pops the scoreboard on every accepted byte and tallies pulses.
    always @(negedge clk) begin
        if (rst_n) begin
            if (rx_valid) valid_cycles++;
            if (busy) busy_cycles++;
            if (frame_err) fe_cnt++;
            if (overrun) ov_cnt++;
`ifdef UART_RX_PARITY_EN
            if (parity_err) pe_cnt++;
            if (parity_err | frame_err)
                chk("parity_frame_exclusive", {31'b0, parity_err & frame_err}, 32'd0);
`endif
            if (frame_err | overrun)
                chk("flags_exclusive", {31'b0, frame_err & overrun}, 32'd0);
            if (rx_valid && rx_ready) begin
                chk("pop_expected", {31'b0, exp_q.size() != 0}, 32'd1);
                if (exp_q.size() != 0) chk("pop_data", {24'b0, rx_data}, {24'b0, exp_q.pop_front()});
            end
        end
    end

    initial begin
        rst_n    = 1'b0;
        rxd      = 1'b1;
        rx_ready = 1'b0;
        clear_stats();
        clks(3);
        chk("rst_valid", {31'b0, rx_valid}, 32'd0);
        chk("rst_data", {24'b0, rx_data}, 32'd0);
        chk("rst_busy", {31'b0, busy}, 32'd0);
        chk("rst_frame_err", {31'b0, frame_err}, 32'd0);
        chk("rst_overrun", {31'b0, overrun}, 32'd0);
        rst_n = 1'b1;
        clks(5);

        // Single byte, consumer always ready.
        clear_stats();
        rx_ready = 1'b1;
        send(8'hA5, 1'b1, 1'b1, 1'b0);
        clks(20);
        chk("t1_valid_cycles", valid_cycles, 32'd1);
        chk("t1_frame_err", fe_cnt, 32'd0);
        chk("t1_overrun", ov_cnt, 32'd0);
        chk("t1_drained", exp_q.size(), 32'd0);
        chk("t1_busy_idle", {31'b0, busy}, 32'd0);

        // Back-to-back frames buffered, then drained in order.
        clear_stats();
        rx_ready = 1'b0;
        send(8'h00, 1'b1, 1'b1, 1'b0);
        send(8'hFF, 1'b1, 1'b1, 1'b0);
        send(8'h3C, 1'b1, 1'b1, 1'b0);
        clks(20);
        chk("t2_valid", {31'b0, rx_valid}, 32'd1);
        chk("t2_head", {24'b0, rx_data}, 32'h00);
        chk("t2_frame_err", fe_cnt, 32'd0);
        rx_ready = 1'b1;
        clks(5);
        rx_ready = 1'b0;
        chk("t2_drained", exp_q.size(), 32'd0);
        chk("t2_valid_low", {31'b0, rx_valid}, 32'd0);

        // Short low glitch is rejected at the half-bit check.
        clear_stats();
        rxd = 1'b0;
        clks(4);
        rxd = 1'b1;
        clks(30);
        chk("t3_busy_cycles", busy_cycles, 32'd8);
        chk("t3_no_data", valid_cycles, 32'd0);
        chk("t3_no_flag", fe_cnt + ov_cnt, 32'd0);
        chk("t3_idle", {31'b0, busy}, 32'd0);

        // Bad stop bit.
        clear_stats();
        send(8'h55, 1'b0, 1'b0, 1'b0);
        clks(40);
        chk("t4_frame_err", fe_cnt, 32'd1);
        chk("t4_no_data", valid_cycles, 32'd0);
        chk("t4_overrun", ov_cnt, 32'd0);

        // Five bytes into a four-entry FIFO: fifth dropped.
        clear_stats();
        for (int i = 1; i <= 5; i++) send(8'(i), 1'b1, (i <= 4), 1'b0);
        clks(20);
        chk("t5a_overrun", ov_cnt, 32'd1);
        chk("t5a_frame_err", fe_cnt, 32'd0);
        chk("t5a_head", {24'b0, rx_data}, 32'h01);
        rx_ready = 1'b1;
        clks(8);
        rx_ready = 1'b0;
        chk("t5a_drained", exp_q.size(), 32'd0);
        chk("t5a_valid_low", {31'b0, rx_valid}, 32'd0);

        // Same, but a pop coincides with the fifth push.
        clear_stats();
        for (int i = 1; i <= 4; i++) send(8'(i), 1'b1, 1'b1, 1'b0);
        send(8'h05, 1'b1, 1'b1, 1'b1);
        clks(20);
        chk("t5b_overrun", ov_cnt, 32'd0);
        chk("t5b_pending", exp_q.size(), 32'd4);
        chk("t5b_head", {24'b0, rx_data}, 32'h02);
        rx_ready = 1'b1;
        clks(8);
        rx_ready = 1'b0;
        chk("t5b_drained", exp_q.size(), 32'd0);
        chk("t5b_valid_low", {31'b0, rx_valid}, 32'd0);

        // Reset in the middle of a frame with a byte still buffered.
        send(8'h99, 1'b1, 1'b1, 1'b0);
        clks(5);
        rxd = 1'b0;
        clks(BIT_CLKS);
        rxd = 1'b1;
        clks(BIT_CLKS);
        rxd = 1'b0;
        clks(20);
        chk("t6_busy_mid", {31'b0, busy}, 32'd1);
        chk("t6_valid_before", {31'b0, rx_valid}, 32'd1);
        rst_n = 1'b0;
        #1;
        chk("t6_rst_valid", {31'b0, rx_valid}, 32'd0);
        chk("t6_rst_data", {24'b0, rx_data}, 32'd0);
        chk("t6_rst_busy", {31'b0, busy}, 32'd0);
        chk("t6_rst_flags", {30'b0, frame_err, overrun}, 32'd0);
        exp_q.delete();
        rxd = 1'b1;
        clks(3);
        rst_n = 1'b1;
        clks(5);
        clear_stats();
        rx_ready = 1'b1;
        send(8'h42, 1'b1, 1'b1, 1'b0);
        clks(20);
        chk("t6_valid_cycles", valid_cycles, 32'd1);
        chk("t6_drained", exp_q.size(), 32'd0);
        chk("t6_flags", fe_cnt + ov_cnt, 32'd0);

`ifdef UART_RX_PARITY_EN
        // Wrong even-parity bit on 0x07: byte discarded, parity_err pulses once.
        clear_stats();
        par_flip = 1'b1;
        send(8'h07, 1'b1, 1'b0, 1'b0);
        par_flip = 1'b0;
        clks(20);
        chk("t7_parity_err", pe_cnt, 32'd1);
        chk("t7_no_data", valid_cycles, 32'd0);
        chk("t7_frame_err", fe_cnt, 32'd0);
`endif

        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

endmodule
